// File: rtl/vertex_streamer.sv
// vertex_streamer: fetches a contiguous run of 128-bit vertex words from BRAM
// and presents each one as four 32-bit lanes on a valid/ready handshake.
module vertex_streamer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W-1:0] count_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [127:0]      mem_data_in,
  output logic [31:0]       pos_out [3:0],
  output logic              valid_out,
  input  logic              ready_in,
  output logic              obj_done_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int unsigned LAT_W  = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [WORD_W-1:0] pos_q [LANES-1:0];
  logic [WORD_W-1:0] pos_d [LANES-1:0];
  logic              valid_q, valid_d;
  logic              obj_done_q, obj_done_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer_c;

  assign xfer_c = valid_q & ready_in;

  // Next-state and next-output computation for the fetch/present sequencer.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    lat_d       = lat_q;
    pos_d       = pos_q;
    valid_d     = valid_q;
    obj_done_d  = obj_done_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (count_in != '0) begin
            mem_addr_d  = base_addr_in;
            remaining_d = count_in;
            lat_d       = '0;
            busy_d      = 1'b1;
            state_d     = S_FETCH;
          end else begin
            // Empty run: report completion without touching memory.
            done_d = 1'b1;
          end
        end
      end

      S_FETCH: begin
        if (lat_q == LAT_W'(MEM_LATENCY - 1)) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            pos_d[i] = mem_data_in[i*WORD_W +: WORD_W];
          end
          valid_d    = 1'b1;
          obj_done_d = (remaining_q == ADDR_W'(1));
          state_d    = S_PRESENT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_PRESENT: begin
        if (xfer_c) begin
          valid_d    = 1'b0;
          obj_done_d = 1'b0;
          if (remaining_q != ADDR_W'(1)) begin
            // Address wraps naturally at the ADDR_W boundary.
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
            lat_d       = '0;
            state_d     = S_FETCH;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      lat_q       <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        pos_q[i] <= '0;
      end
      valid_q     <= 1'b0;
      obj_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      lat_q       <= lat_d;
      pos_q       <= pos_d;
      valid_q     <= valid_d;
      obj_done_q  <= obj_done_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr_out = mem_addr_q;
  assign pos_out      = pos_q;
  assign valid_out    = valid_q;
  assign obj_done_out = obj_done_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_vertex_streamer.sv
// Testbench for vertex_streamer: default instance (ADDR_W=10, latency 2) and a
// small instance (ADDR_W=4, latency 1) each fed by a behavioural BRAM.
`timescale 1ns/1ps
module tb_vertex_streamer;

  localparam int unsigned AW_A  = 10;
  localparam int unsigned AW_B  = 4;
  localparam int          LAT_A = 2;
  localparam int          LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic            start_a, ready_a, valid_a, obj_a, busy_a, done_a;
  logic [AW_A-1:0] base_a, cnt_a, addr_a;
  logic [127:0]    data_a, rd_a;
  logic [31:0]     pos_a [3:0];
  logic [127:0]    mem_a [1024];

  logic            start_b, ready_b, valid_b, obj_b, busy_b, done_b;
  logic [AW_B-1:0] base_b, cnt_b, addr_b;
  logic [127:0]    data_b;
  logic [31:0]     pos_b [3:0];
  logic [127:0]    mem_b [16];

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  // Monitor state
  logic [127:0] xq_a[$], eq_a[$], xq_b[$], eq_b[$];
  logic         xo_a[$], eo_a[$], xo_b[$], eo_b[$];
  int           xc_a[$], xc_b[$];
  int           done_cnt_a, done_cyc_a, valid_seen_a, busy_seen_a;
  int           done_cnt_b;

  vertex_streamer #(.ADDR_W(AW_A), .MEM_LATENCY(LAT_A)) dut_a (
    .clk_in(clk), .rst_in(rst), .start_in(start_a), .base_addr_in(base_a),
    .count_in(cnt_a), .mem_addr_out(addr_a), .mem_data_in(data_a),
    .pos_out(pos_a), .valid_out(valid_a), .ready_in(ready_a),
    .obj_done_out(obj_a), .busy_out(busy_a), .done_out(done_a)
  );

  vertex_streamer #(.ADDR_W(AW_B), .MEM_LATENCY(LAT_B)) dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(start_b), .base_addr_in(base_b),
    .count_in(cnt_b), .mem_addr_out(addr_b), .mem_data_in(data_b),
    .pos_out(pos_b), .valid_out(valid_b), .ready_in(ready_b),
    .obj_done_out(obj_b), .busy_out(busy_b), .done_out(done_b)
  );

  // BRAM models: latency 2 = one read register, latency 1 = combinational read
  always @(posedge clk) rd_a <= mem_a[addr_a];
  assign data_a = rd_a;
  assign data_b = mem_b[addr_b];

  always @(posedge clk) cyc++;

  // Transfer monitor; inputs only change just after posedge so negedge is stable
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a) valid_seen_a++;
      if (busy_a) busy_seen_a++;
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
      end
      if (valid_a && ready_a) begin
        xq_a.push_back({pos_a[3], pos_a[2], pos_a[1], pos_a[0]});
        xo_a.push_back(obj_a);
        xc_a.push_back(cyc + 1);
      end
      if (done_b) done_cnt_b++;
      if (valid_b && ready_b) begin
        xq_b.push_back({pos_b[3], pos_b[2], pos_b[1], pos_b[0]});
        xo_b.push_back(obj_b);
        xc_b.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    xq_a.delete(); xo_a.delete(); xc_a.delete(); eq_a.delete(); eo_a.delete();
    xq_b.delete(); xo_b.delete(); xc_b.delete(); eq_b.delete(); eo_b.delete();
    done_cnt_a = 0; done_cyc_a = -1; valid_seen_a = 0; busy_seen_a = 0;
    done_cnt_b = 0;
  endtask

  // Reference model: a run is count consecutive words from base, mod memory size
  task automatic model_a(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      eq_a.push_back(mem_a[(base + i) % 1024]);
      eo_a.push_back(i == count - 1);
    end
  endtask

  task automatic model_b(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      eq_b.push_back(mem_b[(base + i) % 16]);
      eo_b.push_back(i == count - 1);
    end
  endtask

  // Issue a one-cycle start on instance A; returns the edge that samples it
  task automatic start_run_a(input int base, input int count, output int s);
    start_a = 1'b1;
    base_a  = AW_A'(base);
    cnt_a   = AW_A'(count);
    s = cyc + 1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int n, input int bound);
    int k = 0;
    while (done_cnt_a < n && k < bound) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    asserts++;
    if ({valid_a, obj_a, busy_a, done_a, addr_a, pos_a[3], pos_a[2], pos_a[1], pos_a[0]} !== '0) begin
      fails++;
      $display("FAIL reset_a: v=%b o=%b b=%b d=%b addr=%h pos3=%h required all 0",
               valid_a, obj_a, busy_a, done_a, addr_a, pos_a[3]);
    end
    asserts++;
    if ({valid_b, obj_b, busy_b, done_b, addr_b, pos_b[3], pos_b[2], pos_b[1], pos_b[0]} !== '0) begin
      fails++;
      $display("FAIL reset_b: v=%b o=%b b=%b d=%b addr=%h required all 0",
               valid_b, obj_b, busy_b, done_b, addr_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s;
    clear_mon();
    ready_a = 1'b1;
    start_run_a(5, 3, s);
    model_a(5, 3);
    wait_done_a(1, 40);
    repeat (5) tick();
    asserts++;
    if (xq_a.size() != 3) begin
      fails++;
      $display("FAIL basic_count: got %0d transfers, required 3", xq_a.size());
    end
    for (int i = 0; i < xq_a.size() && i < 3; i++) begin
      asserts++;
      if (xq_a[i] !== eq_a[i] || xo_a[i] !== eo_a[i]) begin
        fails++;
        $display("FAIL basic_data[%0d]: got %h/%b required %h/%b", i, xq_a[i], xo_a[i], eq_a[i], eo_a[i]);
      end
      asserts++;
      if (xc_a[i] !== s + (LAT_A + 1) * (i + 1)) begin
        fails++;
        $display("FAIL basic_timing[%0d]: transfer at edge %0d required %0d", i, xc_a[i] - s, (LAT_A + 1) * (i + 1));
      end
    end
    asserts++;
    if (done_cnt_a != 1 || done_cyc_a != s + 3 * (LAT_A + 1)) begin
      fails++;
      $display("FAIL basic_done: count %0d at edge %0d required 1 at %0d",
               done_cnt_a, done_cyc_a - s, 3 * (LAT_A + 1));
    end
  endtask

  task automatic test_backpressure();
    int s, v, k;
    clear_mon();
    ready_a = 1'b1;
    start_run_a(5, 3, s);
    model_a(5, 3);
    k = 0;
    while (xq_a.size() < 1 && k < 20) begin tick(); k++; end
    ready_a = 1'b0;
    k = 0;
    while (!valid_a && k < 20) begin tick(); k++; end
    v = cyc;
    for (int i = 0; i < 10; i++) begin
      asserts++;
      if ({valid_a, obj_a, pos_a[3], pos_a[2], pos_a[1], pos_a[0]} !== {1'b1, 1'b0, mem_a[6]}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: v=%b o=%b pos=%h%h%h%h required 1/0/%h", i, valid_a, obj_a,
                 pos_a[3], pos_a[2], pos_a[1], pos_a[0], mem_a[6]);
      end
      tick();
    end
    ready_a = 1'b1;
    wait_done_a(1, 40);
    repeat (3) tick();
    asserts++;
    if (xq_a.size() != 3) begin
      fails++;
      $display("FAIL bp_count: got %0d transfers, required 3", xq_a.size());
    end
    for (int i = 0; i < xq_a.size() && i < 3; i++) begin
      asserts++;
      if (xq_a[i] !== eq_a[i] || xo_a[i] !== eo_a[i]) begin
        fails++;
        $display("FAIL bp_data[%0d]: got %h/%b required %h/%b", i, xq_a[i], xo_a[i], eq_a[i], eo_a[i]);
      end
    end
    asserts++;
    if (xc_a.size() < 2 || xc_a[1] != v + 11) begin
      fails++;
      $display("FAIL bp_release: second transfer at %0d required %0d", (xc_a.size() < 2) ? -1 : xc_a[1], v + 11);
    end
  endtask

  task automatic test_zero_count();
    int s;
    clear_mon();
    ready_a = 1'b1;
    start_run_a(0, 0, s);
    repeat (10) tick();
    asserts++;
    if (done_cnt_a != 1 || done_cyc_a != s) begin
      fails++;
      $display("FAIL zero_done: count %0d at edge %0d required 1 at 0", done_cnt_a, done_cyc_a - s);
    end
    asserts++;
    if (valid_seen_a != 0 || busy_seen_a != 0) begin
      fails++;
      $display("FAIL zero_quiet: valid cycles %0d busy cycles %0d required 0/0", valid_seen_a, busy_seen_a);
    end
  endtask

  task automatic test_start_while_busy();
    int s;
    clear_mon();
    ready_a = 1'b1;
    start_run_a(5, 3, s);
    model_a(5, 3);
    repeat (3) tick();
    start_a = 1'b1; base_a = AW_A'(20); cnt_a = AW_A'(5);
    tick();
    start_a = 1'b0;
    wait_done_a(1, 40);
    repeat (20) tick();
    asserts++;
    if (xq_a.size() != 3 || done_cnt_a != 1) begin
      fails++;
      $display("FAIL busy_ignore: %0d transfers %0d dones required 3/1", xq_a.size(), done_cnt_a);
    end
    for (int i = 0; i < xq_a.size() && i < 3; i++) begin
      asserts++;
      if (xq_a[i] !== eq_a[i] || xo_a[i] !== eo_a[i]) begin
        fails++;
        $display("FAIL busy_data[%0d]: got %h/%b required %h/%b", i, xq_a[i], xo_a[i], eq_a[i], eo_a[i]);
      end
    end
  endtask

  task automatic test_wrap_latency();
    int s, k;
    clear_mon();
    ready_b = 1'b1;
    start_b = 1'b1; base_b = AW_B'(15); cnt_b = AW_B'(2);
    s = cyc + 1;
    tick();
    start_b = 1'b0;
    model_b(15, 2);
    k = 0;
    while (done_cnt_b < 1 && k < 30) begin tick(); k++; end
    repeat (3) tick();
    asserts++;
    if (xq_b.size() != 2 || done_cnt_b != 1) begin
      fails++;
      $display("FAIL wrap_count: %0d transfers %0d dones required 2/1", xq_b.size(), done_cnt_b);
    end
    for (int i = 0; i < xq_b.size() && i < 2; i++) begin
      asserts++;
      if (xq_b[i] !== eq_b[i] || xo_b[i] !== eo_b[i] || xc_b[i] != s + (LAT_B + 1) * (i + 1)) begin
        fails++;
        $display("FAIL wrap_data[%0d]: got %h/%b edge %0d required %h/%b edge %0d", i, xq_b[i], xo_b[i],
                 xc_b[i] - s, eq_b[i], eo_b[i], (LAT_B + 1) * (i + 1));
      end
    end
    ready_b = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int s, k;
    clear_mon();
    ready_a = 1'b0;
    start_run_a(5, 3, s);
    k = 0;
    while (!valid_a && k < 20) begin tick(); k++; end
    #2;
    rst = 1'b1;
    #1;
    asserts++;
    if ({valid_a, obj_a, busy_a, done_a, addr_a, pos_a[3], pos_a[2], pos_a[1], pos_a[0]} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: v=%b o=%b b=%b d=%b addr=%h pos3=%h required all 0",
               valid_a, obj_a, busy_a, done_a, addr_a, pos_a[3]);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    asserts++;
    if (done_cnt_a != 0 || xq_a.size() != 0) begin
      fails++;
      $display("FAIL midreset_quiet: %0d dones %0d transfers required 0/0", done_cnt_a, xq_a.size());
    end
    clear_mon();
    ready_a = 1'b1;
    start_run_a(5, 3, s);
    model_a(5, 3);
    wait_done_a(1, 40);
    repeat (3) tick();
    asserts++;
    if (xq_a.size() != 3 || done_cnt_a != 1) begin
      fails++;
      $display("FAIL midreset_rerun: %0d transfers %0d dones required 3/1", xq_a.size(), done_cnt_a);
    end
    for (int i = 0; i < xq_a.size() && i < 3; i++) begin
      asserts++;
      if (xq_a[i] !== eq_a[i] || xo_a[i] !== eo_a[i]) begin
        fails++;
        $display("FAIL midreset_data[%0d]: got %h/%b required %h/%b", i, xq_a[i], xo_a[i], eq_a[i], eo_a[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2, k;
    clear_mon();
    ready_a = 1'b1;
    start_run_a(100, 1, s1);
    model_a(100, 1);
    k = 0;
    while (!done_a && k < 20) begin tick(); k++; end
    start_run_a(200, 2, s2);
    model_a(200, 2);
    wait_done_a(2, 40);
    repeat (3) tick();
    asserts++;
    if (xq_a.size() != 3 || done_cnt_a != 2) begin
      fails++;
      $display("FAIL b2b_count: %0d transfers %0d dones required 3/2", xq_a.size(), done_cnt_a);
    end
    for (int i = 0; i < xq_a.size() && i < 3; i++) begin
      asserts++;
      if (xq_a[i] !== eq_a[i] || xo_a[i] !== eo_a[i]) begin
        fails++;
        $display("FAIL b2b_data[%0d]: got %h/%b required %h/%b", i, xq_a[i], xo_a[i], eq_a[i], eo_a[i]);
      end
    end
    asserts++;
    if (xc_a.size() < 2 || xc_a[1] != s2 + LAT_A + 1) begin
      fails++;
      $display("FAIL b2b_restart: second run first transfer at %0d required %0d",
               (xc_a.size() < 2) ? -1 : xc_a[1], s2 + LAT_A + 1);
    end
  endtask

  task automatic test_random_runs();
    int s, base, count, k;
    for (int r = 0; r < 8; r++) begin
      clear_mon();
      base  = (r == 0) ? 1021 : int'($urandom_range(0, 1023));
      count = int'($urandom_range(1, 6));
      ready_a = 1'($urandom_range(0, 1));
      start_run_a(base, count, s);
      model_a(base, count);
      k = 0;
      while (done_cnt_a < 1 && k < 300) begin
        ready_a = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      ready_a = 1'b0;
      repeat (3) tick();
      asserts++;
      if (xq_a.size() != count || done_cnt_a != 1) begin
        fails++;
        $display("FAIL rand%0d_count: %0d transfers %0d dones required %0d/1", r, xq_a.size(), done_cnt_a, count);
      end
      for (int i = 0; i < xq_a.size() && i < count; i++) begin
        asserts++;
        if (xq_a[i] !== eq_a[i] || xo_a[i] !== eo_a[i]) begin
          fails++;
          $display("FAIL rand%0d_data[%0d]: got %h/%b required %h/%b", r, i, xq_a[i], xo_a[i], eq_a[i], eo_a[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; ready_a = 1'b0; base_a = '0; cnt_a = '0;
    start_b = 1'b0; ready_b = 1'b0; base_b = '0; cnt_b = '0;
    for (int i = 0; i < 1024; i++) mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 16; i++) mem_b[i] = {$urandom, $urandom, $urandom, 32'(i)};
    clear_mon();

    test_reset();
    test_basic();
    repeat (3) tick();
    test_backpressure();
    repeat (3) tick();
    test_zero_count();
    test_start_while_busy();
    test_wrap_latency();
    test_reset_mid_run();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_random_runs();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
